// File: rtl/qinfen_apb3_master_if.sv
// Command/response channels plus the APB3 bus of the qinfen APB3 requester.
// The master modport is the requester's view; slave is the view of whatever sits around it.
interface qinfen_apb3_master_if #(
    parameter int ADDRWIDTH = 12
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [ADDRWIDTH-1:0] cmd_addr;
    logic [31:0]          cmd_wdata;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;

    logic [ADDRWIDTH-1:0] paddr;
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [31:0]          pwdata;
    logic [31:0]          prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/qinfen_apb3_master.sv
// APB3 requester: one valid/ready command becomes one SETUP+ACCESS transfer and one response beat.
// Optional ACCESS wait-state timeout is enabled by defining QINFEN_APB3_MST_TIMEOUT_EN.
module qinfen_apb3_master #(
    parameter int ADDRWIDTH      = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                pclk,
    input  logic                presetn,
    qinfen_apb3_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic cmd_accept;
    logic access_done;
    logic timeout_hit;

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
        $error("qinfen_apb3_master: TIMEOUT_CYCLES must be at least 2");
    end

    assign cmd_accept    = (state_q == IDLE) && bus.cmd_valid;
    assign access_done   = (state_q == ACCESS) && bus.pready;
    assign bus.cmd_ready = (state_q == IDLE);

`ifdef QINFEN_APB3_MST_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt;

    // Counts completed ACCESS cycles without pready; SETUP always precedes ACCESS, so clear there.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_cnt <= '0;
        end else if (state_q == SETUP) begin
            wait_cnt <= '0;
        end else if ((state_q == ACCESS) && !bus.pready) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // pready on the limit cycle takes priority through access_done in the next-state logic.
    assign timeout_hit = (state_q == ACCESS) && !bus.pready &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (access_done || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus strobes come straight from flops decoded off the next state, so they cannot glitch.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= 1'b0;
        end else begin
            bus.psel      <= (state_d == SETUP) || (state_d == ACCESS);
            bus.penable   <= (state_d == ACCESS);
            bus.rsp_valid <= (state_d == RESP);
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            bus.paddr  <= '0;
            bus.pwrite <= 1'b0;
            bus.pwdata <= '0;
        end else if (cmd_accept) begin
            bus.paddr  <= {bus.cmd_addr[ADDRWIDTH-1:2], 2'b00};
            bus.pwrite <= bus.cmd_write;
            bus.pwdata <= bus.cmd_wdata;
        end
    end

    // prdata is only meaningful for reads; pslverr only counts on the pready cycle.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else if (access_done) begin
            bus.rsp_rdata <= bus.pwrite ? 32'h0 : bus.prdata;
            bus.rsp_err   <= bus.pslverr;
        end else if (timeout_hit) begin
            bus.rsp_rdata <= 32'h0;
            bus.rsp_err   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_qinfen_apb3_master.sv
// Randomised bench for qinfen_apb3_master: an APB3 slave with wait states and an error window,
// plus a word-level memory model predicting every response beat.
module tb_qinfen_apb3_master;

    localparam int TB_TIMEOUT = 16;

    logic pclk;
    logic presetn;

    qinfen_apb3_master_if #(.ADDRWIDTH(12)) bus ();

    qinfen_apb3_master #(
        .ADDRWIDTH      (12),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    int test_count = 0;
    int fail_count = 0;
    int cyc = 0;

    logic [31:0] slv_mem [0:1023];
    logic [31:0] model_mem [0:1023];
    int slv_waits = 0;
    bit slv_stuck = 0;
    int slv_cnt = 0;

    int prev_acc = -1;
    int prev_len = 0;

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    always @(posedge pclk) cyc++;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Slaves answer with an error for anything in 0xA00-0xAFF.
    function automatic logic err_region(input logic [11:0] a);
        return a[11:8] == 4'hA;
    endfunction

    function automatic logic [31:0] err_word(input logic [11:0] a);
        return 32'hBAD0_0000 | {20'h0, a[11:2], 2'b00};
    endfunction

    function automatic void model_predict(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                                          output logic [31:0] rd, output logic er);
        er = err_region(a);
        if (wr) begin
            rd = 32'h0;
            if (!er) model_mem[a[11:2]] = wd;
        end else begin
            rd = er ? err_word(a) : model_mem[a[11:2]];
        end
    endfunction

    // APB3 slave: drives junk whenever its outputs should be ignored.
    always @(negedge pclk) begin
        if (bus.psel === 1'b1 && bus.penable === 1'b1) begin
            if (!slv_stuck && slv_cnt >= slv_waits) begin
                bus.pready  = 1'b1;
                bus.pslverr = err_region(bus.paddr);
                if (bus.pwrite)                  bus.prdata = $urandom;
                else if (err_region(bus.paddr))  bus.prdata = err_word(bus.paddr);
                else                             bus.prdata = slv_mem[bus.paddr[11:2]];
            end else begin
                bus.pready  = 1'b0;
                bus.pslverr = 1'($urandom);
                bus.prdata  = $urandom;
            end
            slv_cnt++;
        end else begin
            slv_cnt     = 0;
            bus.pready  = 1'($urandom);
            bus.pslverr = 1'($urandom);
            bus.prdata  = $urandom;
        end
    end

    always @(posedge pclk) begin
        if (presetn === 1'b1 && bus.psel === 1'b1 && bus.penable === 1'b1 &&
            bus.pready === 1'b1 && bus.pwrite === 1'b1 && !err_region(bus.paddr))
            slv_mem[bus.paddr[11:2]] = bus.pwdata;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge where cmd_ready is back after the response.
    task automatic applyStimulus(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                                 input int waits, input int delay);
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [11:0] exp_addr;
        int acc;
        int n;
        int pen_cycles;
        exp_addr  = {addr[11:2], 2'b00};
        slv_waits = waits;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge pclk);
            n++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            checkOutput("accept_wait", 0, 1);
            bus.cmd_valid = 1'b0;
            prev_acc = -1;
            return;
        end
        acc = cyc;
        if (prev_acc >= 0) checkOutput("accept_spacing", acc - prev_acc, prev_len);
        model_predict(wr, addr, wd, exp_rdata, exp_err);

        @(negedge pclk);
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = 12'($urandom);
        bus.cmd_wdata = $urandom;
        checkOutput("setup_sel_en", {bus.psel, bus.penable}, 2'b10);
        checkOutput("setup_paddr", bus.paddr, exp_addr);
        checkOutput("setup_pwrite", bus.pwrite, wr);
        if (wr) checkOutput("setup_pwdata", bus.pwdata, wd);
        checkOutput("setup_cmd_ready", bus.cmd_ready, 0);

        @(negedge pclk);
        n = 0;
        pen_cycles = 0;
        while (bus.rsp_valid !== 1'b1 && n < waits + 20) begin
            if (bus.psel === 1'b1 && bus.penable === 1'b1) pen_cycles++;
            checkOutput("access_paddr", bus.paddr, exp_addr);
            @(negedge pclk);
            n++;
        end
        if (bus.rsp_valid !== 1'b1) begin
            checkOutput("rsp_wait", 0, 1);
            bus.cmd_valid = 1'b0;
            prev_acc = -1;
            return;
        end
        checkOutput("rsp_latency", cyc - acc, 3 + waits);
        checkOutput("penable_cycles", pen_cycles, waits + 1);
        checkOutput("resp_sel_en", {bus.psel, bus.penable}, 2'b00);
        checkOutput("rsp_rdata", bus.rsp_rdata, exp_rdata);
        checkOutput("rsp_err", bus.rsp_err, exp_err);

        for (int i = 0; i < delay; i++) begin
            @(negedge pclk);
            checkOutput("rsp_hold", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.cmd_ready, bus.psel},
                        {1'b1, exp_err, exp_rdata, 2'b00});
        end
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b0;
        @(negedge pclk);
        bus.rsp_ready = 1'b0;
        checkOutput("rsp_consumed", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
        prev_acc = acc;
        prev_len = 4 + waits + delay;
    endtask

    logic [11:0] r_addr;
    int st_acc;
    int n;
    bit lost;

    initial begin
        presetn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            slv_mem[i]   = 32'h0;
            model_mem[i] = 32'h0;
        end
        slv_mem[10'h3F8] = 32'h0000_0018;  model_mem[10'h3F8] = 32'h0000_0018;
        slv_mem[10'h3FB] = 32'h0000_0030;  model_mem[10'h3FB] = 32'h0000_0030;

        repeat (3) @(negedge pclk);
        checkOutput("reset_strobes", {bus.psel, bus.penable, bus.rsp_valid}, 3'b000);
        checkOutput("reset_cmd_ready", bus.cmd_ready, 1);
        checkOutput("reset_bus_regs", {bus.pwrite, bus.paddr, bus.pwdata}, 45'h0);
        checkOutput("reset_rsp_regs", {bus.rsp_rdata, bus.rsp_err}, 33'h0);
        presetn = 1'b1;
        @(negedge pclk);

        applyStimulus(1'b1, 12'h004, 32'hA5A5_1234, 0, 0);
        applyStimulus(1'b0, 12'h004, 32'h0, 0, 0);
        applyStimulus(1'b0, 12'hFE0, 32'h0, 0, 0);
        applyStimulus(1'b0, 12'hFEC, 32'h0, 0, 0);
        applyStimulus(1'b0, 12'h004, 32'h0, 3, 0);
        applyStimulus(1'b1, 12'hA10, 32'hDEAD_BEEF, 0, 0);
        applyStimulus(1'b1, 12'h008, 32'h1111_2222, 0, 0);
        applyStimulus(1'b0, 12'h00B, 32'h0, 1, 5);
        applyStimulus(1'b0, 12'h010, 32'h0, TB_TIMEOUT - 1, 0);

        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 3))
                0, 1:    r_addr = 12'($urandom_range(0, 63));
                2:       r_addr = 12'hA00 | 12'($urandom_range(0, 63));
                default: r_addr = 12'hFE0 | 12'($urandom_range(0, 15));
            endcase
            applyStimulus(1'($urandom), r_addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Slave never answers.
        prev_acc      = -1;
        slv_stuck     = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 12'h020;
        st_acc = cyc;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
`ifdef QINFEN_APB3_MST_TIMEOUT_EN
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 60) begin
            @(negedge pclk);
            n++;
        end
        checkOutput("timeout_latency", cyc - st_acc, 2 + TB_TIMEOUT);
        checkOutput("timeout_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.psel, bus.penable},
                    {2'b11, 32'h0, 2'b00});
        bus.rsp_ready = 1'b1;
        @(negedge pclk);
        bus.rsp_ready = 1'b0;
        checkOutput("timeout_consumed", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 12'h024;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        repeat (5) @(negedge pclk);
`else
        lost = 1'b0;
        repeat (100) begin
            @(negedge pclk);
            if (bus.psel !== 1'b1 || bus.penable !== 1'b1 || bus.rsp_valid !== 1'b0) lost = 1'b1;
        end
        checkOutput("stuck_access_held", lost, 0);
`endif
        checkOutput("pre_reset_access", {bus.psel, bus.penable}, 2'b11);
        #2 presetn = 1'b0;
        #1 checkOutput("reset_async", {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready}, 4'b0001);
        @(negedge pclk);
        presetn   = 1'b1;
        slv_stuck = 1'b0;
        lost      = 1'b0;
        repeat (6) begin
            @(negedge pclk);
            if (bus.rsp_valid !== 1'b0 || bus.psel !== 1'b0) lost = 1'b1;
        end
        checkOutput("no_replay", lost, 0);
        applyStimulus(1'b0, 12'h004, 32'h0, 1, 1);
        applyStimulus(1'b0, 12'h008, 32'h0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
